// File: rtl/audio_pkg.sv
// Audio path shared definitions.
//   i2c_transaction_t : re-exported from i2c_types
//   writer_state_t    : DAC writer FSM states
//   DAC_ADDR_DEFAULT  : default 7-bit I2C address of the DAC
//   sat_width()       : width of an unsaturated N-channel sum
package audio_pkg;
    typedef i2c_types::i2c_transaction_t i2c_transaction_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } writer_state_t;

    localparam logic [6:0] DAC_ADDR_DEFAULT = 7'h62;

    // One spare bit above the exact sum width keeps the accumulator wrap-free.
    function automatic int unsigned sat_width(input int unsigned n, input int unsigned w);
        return w + $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/i2c_types.sv
// Shared I2C transaction types used by the i2c_controller and its clients.
//   i2c_transaction_t : kind of transfer requested from the controller.
package i2c_types;
    typedef enum logic [1:0] {
        READ_8BIT_REGISTER   = 2'd0,
        WRITE_8BIT_REGISTER  = 2'd1,
        WRITE_12BIT_REGISTER = 2'd2,
        READ_12BIT_REGISTER  = 2'd3
    } i2c_transaction_t;
endpackage

// File: rtl/audio_dac_streamer_fifo.sv
// sample_fifo: synchronous FIFO, parametrised width/depth (depth power of two).
//   clk, rst        : clock, synchronous active-high reset (empties FIFO)
//   push, push_data : write request and data (ignored when full unless popping)
//   pop, pop_data   : read request and current head (ignored when empty)
//   full, empty     : status flags
//   level           : number of entries stored
module sample_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == LVL_FULL);
    assign level    = count;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/audio_dac_streamer.sv
// audio_dac_streamer: N-channel mixer feeding a sample-rate-paced I2C DAC writer.
//   clk, rst      : clock, synchronous active-high reset
//   ena           : enables sample ticks (FIFO keeps draining when low)
//   ch_data       : packed unsigned channel samples, channel k at [k*CH_W +: CH_W]
//   ch_mask       : 1 = channel included in the mix
//   mix_out       : last mixed, saturated sample
//   i2c_valid/ready, i2c_addr, i2c_data, i2c_mode : request to i2c_controller
//   fifo_level    : queued samples
//   overflow_cnt  : dropped samples, saturating at 255
//   underrun      : sticky, tick found nothing to send after the first write
module audio_dac_streamer
    import audio_pkg::*;
#(
    parameter int unsigned N_CHANNELS = 4,
    parameter int unsigned CH_W       = 11,
    parameter int unsigned DAC_W      = 12,
    parameter int unsigned MIX_SHIFT  = 1,
    parameter int unsigned CLK_HZ     = 400_000,
    parameter int unsigned SAMPLE_HZ  = 8_000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [6:0]  DAC_ADDR   = DAC_ADDR_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ena,
    input  logic [N_CHANNELS*CH_W-1:0]     ch_data,
    input  logic [N_CHANNELS-1:0]          ch_mask,
    output logic [DAC_W-1:0]               mix_out,
    output logic                           i2c_valid,
    input  logic                           i2c_ready,
    output logic [6:0]                     i2c_addr,
    output logic [DAC_W-1:0]               i2c_data,
    output i2c_transaction_t               i2c_mode,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic [7:0]                     overflow_cnt,
    output logic                           underrun
);
    localparam int unsigned TICK_DIV = CLK_HZ / SAMPLE_HZ;
    localparam int unsigned TW       = $clog2(TICK_DIV);
    localparam int unsigned SUM_W    = sat_width(N_CHANNELS, CH_W);
    localparam int unsigned CMP_W    = (SUM_W > DAC_W) ? SUM_W : DAC_W;

    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [SUM_W-1:0]  sum;
    logic [CMP_W-1:0]  scaled;
    logic [DAC_W-1:0]  mix_sat;
    logic              push_pend;
    logic [DAC_W-1:0]  fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    writer_state_t     state;
    logic              seen_low;
    logic              wrote;

    assign i2c_addr = DAC_ADDR;
    assign i2c_mode = i2c_types::WRITE_12BIT_REGISTER;

    // Tick generator
    assign tick = ena && (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !ena || tick) tick_cnt <= '0;
        else                     tick_cnt <= tick_cnt + TW'(1);
    end

    // Mixer
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < N_CHANNELS; k++) begin
            if (ch_mask[k]) sum = sum + SUM_W'(ch_data[k*CH_W +: CH_W]);
        end
        scaled  = CMP_W'(sum >> MIX_SHIFT);
        mix_sat = (scaled > CMP_W'({DAC_W{1'b1}})) ? '1 : scaled[DAC_W-1:0];
    end

    // The registered mix result is pushed one cycle after the tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            mix_out   <= '0;
            push_pend <= 1'b0;
        end else begin
            push_pend <= tick;
            if (tick) mix_out <= mix_sat;
        end
    end

    assign fifo_pop = (state == S_IDLE) && !fifo_empty && i2c_ready;

    sample_fifo #(
        .WIDTH (DAC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_pend),
        .push_data (mix_out),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_cnt <= '0;
        end else if (push_pend && fifo_full && !fifo_pop && (overflow_cnt != 8'hFF)) begin
            overflow_cnt <= overflow_cnt + 8'd1;
        end
    end

    // Writer FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            i2c_valid <= 1'b0;
            i2c_data  <= '0;
            seen_low  <= 1'b0;
            wrote     <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            if (tick && fifo_empty && (state == S_IDLE) && wrote) underrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (fifo_pop) begin
                        i2c_data  <= fifo_head;
                        i2c_valid <= 1'b1;
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i2c_valid && i2c_ready) begin
                        i2c_valid <= 1'b0;
                        seen_low  <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Completion is the first ready=1 after at least one low cycle.
                    if (!i2c_ready) begin
                        seen_low <= 1'b1;
                    end else if (seen_low) begin
                        wrote <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_dac_streamer.sv
// Testbench for audio_dac_streamer: scoreboard of expected DAC writes,
// a small i2c_controller responder, and per-tick mix checks. A second
// instance with MIX_SHIFT=0 checks saturation.
module tb_audio_dac_streamer;
    localparam int unsigned TICK_DIV   = 50;
    localparam int unsigned FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [43:0] ch_data;
    logic [3:0]  ch_mask;
    logic [11:0] mix_out;
    logic        i2c_valid;
    logic        i2c_ready;
    logic [6:0]  i2c_addr;
    logic [11:0] i2c_data;
    i2c_types::i2c_transaction_t i2c_mode;
    logic [3:0]  fifo_level;
    logic [7:0]  overflow_cnt;
    logic        underrun;

    logic        sat_ready = 1'b0;
    logic [11:0] sat_mix_out;
    logic        sat_valid;
    logic [6:0]  sat_addr;
    logic [11:0] sat_data;
    i2c_types::i2c_transaction_t sat_mode;
    logic [3:0]  sat_level;
    logic [7:0]  sat_ovf;
    logic        sat_underrun;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned wr_count = 0;

    logic        hold_ready;
    logic        fill_mode;
    int unsigned busy;
    int unsigned m_cnt;
    logic        m_tick;
    int unsigned fill_cnt;
    int unsigned exp_ovf;
    logic        mix_chk = 1'b0;
    logic [11:0] mix_exp;
    logic [11:0] sat_exp;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    audio_dac_streamer #(
        .N_CHANNELS (4), .CH_W (11), .DAC_W (12), .MIX_SHIFT (1),
        .CLK_HZ (400_000), .SAMPLE_HZ (8_000), .FIFO_DEPTH (FIFO_DEPTH), .DAC_ADDR (7'h62)
    ) dut (
        .clk (clk), .rst (rst), .ena (ena), .ch_data (ch_data), .ch_mask (ch_mask),
        .mix_out (mix_out), .i2c_valid (i2c_valid), .i2c_ready (i2c_ready),
        .i2c_addr (i2c_addr), .i2c_data (i2c_data), .i2c_mode (i2c_mode),
        .fifo_level (fifo_level), .overflow_cnt (overflow_cnt), .underrun (underrun)
    );

    audio_dac_streamer #(
        .N_CHANNELS (4), .CH_W (11), .DAC_W (12), .MIX_SHIFT (0),
        .CLK_HZ (400_000), .SAMPLE_HZ (8_000), .FIFO_DEPTH (FIFO_DEPTH), .DAC_ADDR (7'h62)
    ) u_sat (
        .clk (clk), .rst (rst), .ena (ena), .ch_data (ch_data), .ch_mask (ch_mask),
        .mix_out (sat_mix_out), .i2c_valid (sat_valid), .i2c_ready (sat_ready),
        .i2c_addr (sat_addr), .i2c_data (sat_data), .i2c_mode (sat_mode),
        .fifo_level (sat_level), .overflow_cnt (sat_ovf), .underrun (sat_underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] model_mix(input logic [43:0] d, input logic [3:0] m,
                                              input int unsigned sh);
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            if (m[k]) s = s + 32'(d[k*11 +: 11]);
        end
        s = s >> sh;
        return (s > 32'd4095) ? 12'hFFF : s[11:0];
    endfunction

    // i2c_controller responder: busy for a few cycles after each accepted request.
    assign i2c_ready = !hold_ready && (busy == 0);

    always @(posedge clk) begin
        if (rst)                          busy <= 0;
        else if (i2c_valid && i2c_ready)  busy <= 5;
        else if (busy != 0)               busy <= busy - 1;
    end

    // Tick model and scoreboard producer.
    assign m_tick = ena && (m_cnt == TICK_DIV - 1);

    always @(posedge clk) begin
        mix_chk <= 1'b0;
        if (rst) begin
            m_cnt    <= 0;
            fill_cnt <= 0;
            exp_ovf  <= 0;
            exp_q.delete();
        end else begin
            if (!ena || m_tick) m_cnt <= 0;
            else                m_cnt <= m_cnt + 1;
            if (m_tick) begin
                mix_chk <= 1'b1;
                mix_exp <= model_mix(ch_data, ch_mask, 1);
                sat_exp <= model_mix(ch_data, ch_mask, 0);
                if (fill_mode && fill_cnt >= FIFO_DEPTH) begin
                    exp_ovf <= exp_ovf + 1;
                end else begin
                    exp_q.push_back(model_mix(ch_data, ch_mask, 1));
                    if (fill_mode) fill_cnt <= fill_cnt + 1;
                end
            end
            if (!fill_mode) fill_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (mix_chk) begin
            check("mix_out", 32'(mix_out), 32'(mix_exp));
            check("mix_sat", 32'(sat_mix_out), 32'(sat_exp));
        end
    end

    // Scoreboard consumer: one check set per accepted request.
    always @(negedge clk) begin
        if (!rst && i2c_valid && i2c_ready) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                check("wr_data", 32'(i2c_data), 32'(exp_q.pop_front()));
                check("wr_addr", 32'(i2c_addr), 32'h62);
                check("wr_mode", 32'(i2c_mode), 32'(i2c_types::WRITE_12BIT_REGISTER));
            end
        end
    end

    task automatic set_ch(input int unsigned d0, input int unsigned d1,
                          input int unsigned d2, input int unsigned d3);
        ch_data = {11'(d3), 11'(d2), 11'(d1), 11'(d0)};
    endtask

    // Returns at the negedge one cycle after a tick edge.
    task automatic wait_tick();
        int unsigned n;
        logic timed_out;
        n = 0;
        timed_out = 1'b0;
        @(negedge clk);
        while (!m_tick && !timed_out) begin
            @(negedge clk);
            n++;
            if (n > 4 * TICK_DIV) timed_out = 1'b1;
        end
        check("tick_wait_timeout", 32'(timed_out), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int unsigned n;
        logic timed_out;
        n = 0;
        timed_out = 1'b0;
        while (!(exp_q.size() == 0 && busy == 0 && !i2c_valid) && !timed_out) begin
            @(negedge clk);
            n++;
            if (n > 2000) timed_out = 1'b1;
        end
        check("drain_timeout", 32'(timed_out), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int unsigned n;
        rst        = 1'b1;
        ena        = 1'b0;
        ch_data    = '0;
        ch_mask    = '0;
        hold_ready = 1'b0;
        fill_mode  = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_mix_out", 32'(mix_out), 0);
        check("rst_valid", 32'(i2c_valid), 0);
        check("rst_data", 32'(i2c_data), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_ovf", 32'(overflow_cnt), 0);
        check("rst_underrun", 32'(underrun), 0);
        check("rst_addr", 32'(i2c_addr), 32'h62);

        // Single tick: (100+300)>>1 = 200
        rst = 1'b0;
        set_ch(100, 300, 55, 77);
        ch_mask = 4'b0011;
        ena = 1'b1;
        wait_tick();
        ena = 1'b0;
        check("single_mix", 32'(mix_out), 200);
        wait_drain();
        check("single_wr_count", wr_count, 1);

        // ena=0: no ticks, no writes, underrun untouched
        repeat (150) @(negedge clk);
        check("ena0_wr_count", wr_count, 1);
        check("ena0_underrun", 32'(underrun), 0);

        // Saturation tick also finds an empty FIFO after a completed write
        set_ch(2047, 2047, 2047, 2047);
        ch_mask = 4'hF;
        ena = 1'b1;
        wait_tick();
        check("underrun_set", 32'(underrun), 1);
        check("sat_shift0", 32'(sat_mix_out), 4095);

        // Mask zero
        ch_mask = 4'h0;
        wait_tick();
        wait_tick();
        ena = 1'b0;
        wait_drain();
        check("mask0_wr_count", wr_count, 4);

        // Overflow: 11 ticks with the controller stalled
        hold_ready = 1'b1;
        fill_mode  = 1'b1;
        ch_mask    = 4'b0001;
        ena        = 1'b1;
        for (int i = 0; i < 11; i++) begin
            set_ch(100 + 7 * i, 0, 0, 0);
            wait_tick();
        end
        ena = 1'b0;
        repeat (3) @(negedge clk);
        check("ovf_level", 32'(fifo_level), 8);
        check("ovf_cnt", 32'(overflow_cnt), 3);
        check("ovf_cnt_model", 32'(overflow_cnt), exp_ovf);
        check("ovf_underrun_sticky", 32'(underrun), 1);
        fill_mode  = 1'b0;
        hold_ready = 1'b0;
        wait_drain();
        check("ovf_wr_count", wr_count, 12);
        check("ovf_level_empty", 32'(fifo_level), 0);

        // Reset while a request is pending in S_SEND
        set_ch(100, 300, 0, 0);
        ch_mask = 4'b0011;
        ena = 1'b1;
        n = 0;
        @(posedge clk); #1;
        while (!i2c_valid && n < 4 * TICK_DIV) begin
            @(posedge clk); #1;
            n++;
        end
        check("send_seen", 32'(i2c_valid), 1);
        hold_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", 32'(i2c_valid), 0);
        check("midrst_level", 32'(fifo_level), 0);
        check("midrst_ovf", 32'(overflow_cnt), 0);
        check("midrst_underrun", 32'(underrun), 0);
        rst = 1'b0;
        hold_ready = 1'b0;
        wait_tick();
        ena = 1'b0;
        check("resume_mix", 32'(mix_out), 200);
        wait_drain();
        check("resume_wr_count", wr_count, 13);
        check("resume_underrun", 32'(underrun), 0);
        check("scoreboard_left", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/audio_dac_streamer.md
Name: audio_dac_streamer

Overview:
- N-channel audio mixer feeding a buffered, sample-rate-paced I2C DAC writer; generalised successor to the single-stream two-channel audio path.
- Mixes N channels with a per-channel enable mask and saturating scale-down on a fixed sample tick, then queues the 12-bit results in a FIFO.
- Drains the FIFO into the external i2c_controller with a valid/ready handshake.
- Sits between the oscillator/channel generators and the shared i2c_controller instance.

Parameters:
- N_CHANNELS, 4, number of input channels (1..16).
- CH_W, 11, width of each unsigned channel sample.
- DAC_W, 12, DAC sample width.
- MIX_SHIFT, 1, right shift applied to the raw sum before saturation.
- CLK_HZ, 400_000, system clock frequency.
- SAMPLE_HZ, 8_000, sample tick rate. TICK_DIV = CLK_HZ/SAMPLE_HZ, must be >= 2.
- FIFO_DEPTH, 8, sample FIFO entries; power of two, >= 2.
- DAC_ADDR, 7'h62, 7-bit I2C address of the DAC.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- ena  in  1  enables sample ticks.
- ch_data  in  N_CHANNELS*CH_W  packed channel samples; channel k at bits [k*CH_W +: CH_W].
- ch_mask  in  N_CHANNELS  1 = channel included in the mix.
- mix_out  out  DAC_W  last mixed sample (registered).
- i2c_valid  out  1  request to i2c_controller.
- i2c_ready  in  1  i2c_controller idle / accepting.
- i2c_addr  out  7  constant DAC_ADDR.
- i2c_data  out  DAC_W  sample being written.
- i2c_mode  out  i2c_transaction_t  always WRITE_12BIT_REGISTER.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued.
- overflow_cnt  out  8  dropped samples, saturates at 255.
- underrun  out  1  sticky; set when a tick finds the FIFO empty and the writer idle after the first write.

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk. On reset:
  - mix_out=0, i2c_valid=0, i2c_data=0, fifo_level=0, overflow_cnt=0, underrun=0.
  - Tick counter=0; FSM in S_IDLE; FIFO emptied.
  - A reset mid-transaction drops i2c_valid immediately. The i2c_controller is reset by the same rst.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 while ena=1 and pulses tick for one cycle on wrap.
  - ena=0 holds the counter at 0; no ticks are generated, but the FIFO keeps draining.
- Mixer, on a tick cycle T:
  - sum = Σ ch_mask[k] ? ch_data[k] : 0, computed at width CH_W+$clog2(N_CHANNELS)+1.
  - scaled = sum >> MIX_SHIFT.
  - mix_out <= (scaled > 2^DAC_W-1) ? 2^DAC_W-1 : scaled.
  - mix_out is valid at T+1. The FIFO push happens at T+1 and the entry is visible at T+2.
- FIFO:
  - Push when FIFO not full. If full, the sample is dropped and overflow_cnt increments unless already 255.
  - A simultaneous push and pop is legal when full (pop frees the slot first) and when empty (level stays 0 only if no push occurred).
  - Pointers wrap modulo FIFO_DEPTH.
- Writer FSM:
  - S_IDLE: if FIFO not empty and i2c_ready, pop the head into i2c_data and go to S_SEND.
  - S_SEND: i2c_valid=1; hold i2c_data stable. On i2c_valid&&i2c_ready the request is accepted and the FSM goes to S_WAIT. i2c_valid is high for at least one cycle.
  - S_WAIT: i2c_valid=0; wait for i2c_ready to fall and rise again, or the first cycle i2c_ready=1 after at least one cycle low, then go to S_IDLE.
  - Only one transaction is outstanding at any time.
- Underrun:
  - Set on a tick when the FIFO is empty, the FSM is in S_IDLE, and at least one write has completed since reset.
  - Cleared only by rst.
- i2c_addr and i2c_mode are constant.

Decomposition:
- audio_pkg holds:
  - reuse of i2c_transaction_t from i2c_types;
  - the writer state enum (S_IDLE, S_SEND, S_WAIT);
  - the DAC_ADDR_DEFAULT constant 7'h62;
  - a sat_width function used by the mixer.
- One sub-module: sample_fifo, a parametrised width/depth synchronous FIFO with full, empty and level outputs.
- Mixer, tick generator and FSM remain in the top module.

Test Plan:
- Reset defaults and single tick: N=4, TICK_DIV=50, mask=4'b0011, ch0=100, ch1=300, MIX_SHIFT=1 -> mix_out=200 one cycle after the tick; a single write with i2c_data=200 and i2c_addr=0x62.
- Saturation: all four channels=2047, mask=4'hF, MIX_SHIFT=0 -> sum=8188; mix_out=4095.
- Mask zero: mask=0 -> mix_out=0 each tick; writes still occur with i2c_data=0.
- Overflow: hold i2c_ready=0 across 11 ticks with FIFO_DEPTH=8 -> fifo_level=8; overflow_cnt=3. Releasing i2c_ready delivers the first 8 samples in order.
- Underrun and ena: after one completed write, set ena=0, then ena=1 with the model stalling FIFO pushes -> underrun=1. ena=0 alone must produce no ticks and leave underrun unchanged.
- Reset mid-transaction: assert rst while in S_SEND -> next cycle i2c_valid=0, fifo_level=0, overflow_cnt=0; normal operation resumes on the next tick.
